// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - common_cells-compatible synchronous FIFO with optional fall-through
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam int unsigned FifoDepth = (DEPTH > 0) ? DEPTH : 1;

    logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
    logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
    logic [ADDR_DEPTH:0]   status_cnt_q, status_cnt_d;
    logic                  do_write;
    dtype                  mem_q [FifoDepth];
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;
    assign usage_o         = status_cnt_q[ADDR_DEPTH-1:0];
    assign full_o          = (status_cnt_q == (ADDR_DEPTH+1)'(FifoDepth));
    assign empty_o         = (status_cnt_q == '0) & ~(FALL_THROUGH & push_i);

    always_comb begin
        read_ptr_d   = read_ptr_q;
        write_ptr_d  = write_ptr_q;
        status_cnt_d = status_cnt_q;
        do_write     = 1'b0;
        data_o       = mem_q[read_ptr_q];

        if (push_i && !full_o) begin
            do_write     = 1'b1;
            write_ptr_d  = (write_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : write_ptr_q + 1'b1;
            status_cnt_d = status_cnt_q + 1'b1;
        end

        if (pop_i && !empty_o) begin
            read_ptr_d   = (read_ptr_q == ADDR_DEPTH'(FifoDepth - 1)) ? '0 : read_ptr_q + 1'b1;
            status_cnt_d = (push_i && !full_o) ? status_cnt_q : status_cnt_q - 1'b1;
        end

        // Fall-through: an incoming word consumed in the same cycle never touches storage.
        if (FALL_THROUGH && (status_cnt_q == '0) && push_i) begin
            data_o = data_i;
            if (pop_i) begin
                status_cnt_d = status_cnt_q;
                read_ptr_d   = read_ptr_q;
                write_ptr_d  = write_ptr_q;
                do_write     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
        end else if (flush_i) begin
            read_ptr_q   <= '0;
            write_ptr_q  <= '0;
            status_cnt_q <= '0;
        end else begin
            read_ptr_q   <= read_ptr_d;
            write_ptr_q  <= write_ptr_d;
            status_cnt_q <= status_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_write) begin
            mem_q[write_ptr_q] <= data_i;
        end
    end
endmodule

// File: rtl/tcdm_bank_resp_adapter.sv
// rtl/tcdm_bank_resp_adapter.sv - credit-gated request path and ordered response buffer for one TCDM bank
module tcdm_bank_resp_adapter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned BeWidth   = DataWidth / 8,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned RespDepth = 2,
    localparam int unsigned OccW     = $clog2(RespDepth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_req_i,
    output logic                 s_gnt_o,
    input  logic [AddrWidth-1:0] s_add_i,
    input  logic                 s_wen_i,
    input  logic [BeWidth-1:0]   s_be_i,
    input  logic [DataWidth-1:0] s_data_i,
    input  logic [IdWidth-1:0]   s_id_i,
    output logic                 s_r_valid_o,
    input  logic                 s_r_ready_i,
    output logic [DataWidth-1:0] s_r_data_o,
    output logic [IdWidth-1:0]   s_r_id_o,
    output logic                 s_r_err_o,
    output logic                 m_req_o,
    output logic [AddrWidth-1:0] m_add_o,
    output logic                 m_wen_o,
    output logic [BeWidth-1:0]   m_be_o,
    output logic [DataWidth-1:0] m_data_o,
    input  logic                 m_gnt_i,
    input  logic [DataWidth-1:0] m_rdata_i,
    input  logic                 m_err_i,
    output logic [OccW-1:0]      occupancy_o
);
    localparam int unsigned AddrDepth = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned Ow1       = OccW + 1;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 err;
        logic [IdWidth-1:0]   id;
    } resp_t;

    logic               pend_q, pend_d;
    logic [IdWidth-1:0] id_q, id_d;
    logic               rd_q, rd_d;
    logic               credit_ok, accept;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [AddrDepth-1:0] fifo_usage;
    logic [OccW-1:0]    count;
    logic [Ow1-1:0]     in_use;
    resp_t              resp_word, head;

    // Usage wraps to zero when the FIFO is completely full, so full_o supplies the top value.
    assign count       = fifo_full ? OccW'(RespDepth) : OccW'(fifo_usage);
    assign occupancy_o = count;

    // A pop in the current cycle deliberately gives no credit back until the next cycle.
    assign in_use    = Ow1'(count) + Ow1'(pend_q);
    assign credit_ok = in_use < Ow1'(RespDepth);

    assign m_req_o  = s_req_i & credit_ok;
    assign s_gnt_o  = m_gnt_i & credit_ok;
    assign m_add_o  = s_add_i;
    assign m_wen_o  = s_wen_i;
    assign m_be_o   = s_be_i;
    assign m_data_o = s_data_i;
    assign accept   = m_req_o & m_gnt_i;

    always_comb begin
        pend_d = accept;
        id_d   = accept ? s_id_i  : id_q;
        rd_d   = accept ? s_wen_i : rd_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q <= 1'b0;
            id_q   <= '0;
            rd_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            id_q   <= id_d;
            rd_q   <= rd_d;
        end
    end

    always_comb begin
        resp_word.data = rd_q ? m_rdata_i : '0;
        resp_word.err  = rd_q & m_err_i;
        resp_word.id   = id_q;
    end

    // Bypass only when nothing is queued ahead and the master takes it now; otherwise enqueue.
    assign fifo_push = pend_q & ~(fifo_empty & s_r_ready_i);
    assign fifo_pop  = ~fifo_empty & s_r_ready_i;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (RespDepth),
        .dtype        (resp_t)
    ) i_resp_fifo (
        .clk_i      (clk_i),
        .rst_ni     (~rst_i),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (resp_word),
        .push_i     (fifo_push),
        .data_o     (head),
        .pop_i      (fifo_pop)
    );

    always_comb begin
        s_r_valid_o = ~fifo_empty | pend_q;
        s_r_data_o  = '0;
        s_r_id_o    = '0;
        s_r_err_o   = 1'b0;
        if (!fifo_empty) begin
            s_r_data_o = head.data;
            s_r_id_o   = head.id;
            s_r_err_o  = head.err;
        end else if (pend_q) begin
            s_r_data_o = resp_word.data;
            s_r_id_o   = resp_word.id;
            s_r_err_o  = resp_word.err;
        end
    end
endmodule

// File: tb/tb_tcdm_bank_resp_adapter.sv
// tb/tb_tcdm_bank_resp_adapter.sv - directed checks of grant gating, response timing, ordering and reset
module tb_tcdm_bank_resp_adapter;
    logic        clk = 1'b0;
    logic        rst_i;
    logic        s_req_i;
    logic        s_gnt_o;
    logic [31:0] s_add_i;
    logic        s_wen_i;
    logic [3:0]  s_be_i;
    logic [31:0] s_data_i;
    logic [0:0]  s_id_i;
    logic        s_r_valid_o;
    logic        s_r_ready_i;
    logic [31:0] s_r_data_o;
    logic [0:0]  s_r_id_o;
    logic        s_r_err_o;
    logic        m_req_o;
    logic [31:0] m_add_o;
    logic        m_wen_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_data_o;
    logic        m_gnt_i;
    logic [31:0] m_rdata_i;
    logic        m_err_i;
    logic [1:0]  occupancy_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    tcdm_bank_resp_adapter dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .s_req_i     (s_req_i),
        .s_gnt_o     (s_gnt_o),
        .s_add_i     (s_add_i),
        .s_wen_i     (s_wen_i),
        .s_be_i      (s_be_i),
        .s_data_i    (s_data_i),
        .s_id_i      (s_id_i),
        .s_r_valid_o (s_r_valid_o),
        .s_r_ready_i (s_r_ready_i),
        .s_r_data_o  (s_r_data_o),
        .s_r_id_o    (s_r_id_o),
        .s_r_err_o   (s_r_err_o),
        .m_req_o     (m_req_o),
        .m_add_o     (m_add_o),
        .m_wen_o     (m_wen_o),
        .m_be_o      (m_be_o),
        .m_data_o    (m_data_o),
        .m_gnt_i     (m_gnt_i),
        .m_rdata_i   (m_rdata_i),
        .m_err_i     (m_err_i),
        .occupancy_o (occupancy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_i       = 1'b1;
        s_req_i     = 1'b0;
        s_add_i     = '0;
        s_wen_i     = 1'b1;
        s_be_i      = 4'hF;
        s_data_i    = '0;
        s_id_i      = 1'b0;
        s_r_ready_i = 1'b1;
        m_gnt_i     = 1'b1;
        m_rdata_i   = '0;
        m_err_i     = 1'b0;
        step();
        step();
        #1;
        chk("rst_valid", s_r_valid_o, 1'b0);
        chk("rst_data", s_r_data_o, 32'h0);
        chk("rst_id", s_r_id_o, 1'b0);
        chk("rst_err", s_r_err_o, 1'b0);
        chk("rst_occ", occupancy_o, 2'd0);
        step();
        rst_i = 1'b0;

        step();
        s_req_i = 1'b1; s_add_i = 32'h10; s_wen_i = 1'b1; s_id_i = 1'b1;
        #1;
        chk("rd_gnt", s_gnt_o, 1'b1);
        chk("rd_add", m_add_o, 32'h10);
        chk("rd_idle_valid", s_r_valid_o, 1'b0);
        step();
        s_req_i = 1'b0; m_rdata_i = 32'hDEADBEEF;
        #1;
        chk("rd_valid", s_r_valid_o, 1'b1);
        chk("rd_data", s_r_data_o, 32'hDEADBEEF);
        chk("rd_id", s_r_id_o, 1'b1);
        chk("rd_err", s_r_err_o, 1'b0);

        step();
        s_req_i = 1'b1; s_wen_i = 1'b0; s_be_i = 4'b0011; s_data_i = 32'h1234; s_id_i = 1'b0;
        #1;
        chk("wr_valid_gap", s_r_valid_o, 1'b0);
        chk("wr_wen", m_wen_o, 1'b0);
        chk("wr_be", m_be_o, 4'b0011);
        chk("wr_wdata", m_data_o, 32'h1234);
        step();
        s_req_i = 1'b0; s_wen_i = 1'b1; s_be_i = 4'hF;
        #1;
        chk("wr_valid", s_r_valid_o, 1'b1);
        chk("wr_data", s_r_data_o, 32'h0);
        chk("wr_id", s_r_id_o, 1'b0);
        step();
        #1;
        chk("wr_done", s_r_valid_o, 1'b0);

        s_r_ready_i = 1'b0; s_req_i = 1'b1; s_id_i = 1'b0;
        #1;
        chk("b2b_gnt0", s_gnt_o, 1'b1);
        step();
        s_id_i = 1'b1; m_rdata_i = 32'hA0;
        #1;
        chk("b2b_gnt1", s_gnt_o, 1'b1);
        chk("b2b_data_a0", s_r_data_o, 32'hA0);
        step();
        m_rdata_i = 32'hA1;
        #1;
        chk("b2b_gnt2_blocked", s_gnt_o, 1'b0);
        chk("b2b_req_blocked", m_req_o, 1'b0);
        chk("b2b_hold_a0", s_r_data_o, 32'hA0);
        step();
        m_rdata_i = 32'hFF;
        #1;
        chk("b2b_occ_full", occupancy_o, 2'd2);
        chk("b2b_full_gnt", s_gnt_o, 1'b0);
        chk("b2b_full_valid", s_r_valid_o, 1'b1);
        s_r_ready_i = 1'b1; s_id_i = 1'b0;
        #1;
        chk("b2b_pop_nocredit", s_gnt_o, 1'b0);
        chk("b2b_head0_data", s_r_data_o, 32'hA0);
        chk("b2b_head0_id", s_r_id_o, 1'b0);
        step();
        #1;
        chk("b2b_gnt2", s_gnt_o, 1'b1);
        chk("b2b_head1_data", s_r_data_o, 32'hA1);
        chk("b2b_head1_id", s_r_id_o, 1'b1);
        step();
        s_id_i = 1'b1; m_rdata_i = 32'hA2;
        #1;
        chk("b2b_gnt3", s_gnt_o, 1'b1);
        chk("b2b_r2_data", s_r_data_o, 32'hA2);
        chk("b2b_r2_id", s_r_id_o, 1'b0);
        step();
        s_req_i = 1'b0; m_rdata_i = 32'hA3;
        #1;
        chk("b2b_r3_data", s_r_data_o, 32'hA3);
        chk("b2b_r3_id", s_r_id_o, 1'b1);
        step();
        #1;
        chk("b2b_drained_valid", s_r_valid_o, 1'b0);
        chk("b2b_drained_occ", occupancy_o, 2'd0);

        s_req_i = 1'b1; m_gnt_i = 1'b0; s_id_i = 1'b1; m_rdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_mreq", m_req_o, 1'b1);
            chk("stall_gnt", s_gnt_o, 1'b0);
            chk("stall_valid", s_r_valid_o, 1'b0);
            step();
        end
        m_gnt_i = 1'b1;
        #1;
        chk("stall_gnt_back", s_gnt_o, 1'b1);
        step();
        s_req_i = 1'b0; m_rdata_i = 32'h55;
        #1;
        chk("stall_resp_valid", s_r_valid_o, 1'b1);
        chk("stall_resp_data", s_r_data_o, 32'h55);
        chk("stall_resp_id", s_r_id_o, 1'b1);
        step();
        #1;
        chk("stall_single", s_r_valid_o, 1'b0);

        s_req_i = 1'b1; s_id_i = 1'b0;
        step();
        s_id_i = 1'b1; m_rdata_i = 32'h11; m_err_i = 1'b1;
        #1;
        chk("err_first", s_r_err_o, 1'b1);
        chk("err_first_id", s_r_id_o, 1'b0);
        step();
        s_req_i = 1'b0; m_rdata_i = 32'h22; m_err_i = 1'b0;
        #1;
        chk("err_second", s_r_err_o, 1'b0);
        chk("err_second_id", s_r_id_o, 1'b1);
        chk("err_second_data", s_r_data_o, 32'h22);
        step();

        s_r_ready_i = 1'b0; s_req_i = 1'b1; s_id_i = 1'b1;
        step();
        s_id_i = 1'b0; m_rdata_i = 32'h77;
        step();
        s_req_i = 1'b0; m_rdata_i = 32'h88;
        #1;
        chk("prerst_occ", occupancy_o, 2'd1);
        chk("prerst_valid", s_r_valid_o, 1'b1);
        rst_i = 1'b1;
        #1;
        chk("midrst_valid", s_r_valid_o, 1'b0);
        chk("midrst_occ", occupancy_o, 2'd0);
        chk("midrst_data", s_r_data_o, 32'h0);
        chk("midrst_id", s_r_id_o, 1'b0);
        step();
        rst_i = 1'b0; s_r_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("postrst_valid", s_r_valid_o, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/tcdm_bank_resp_adapter.md
# tcdm_bank_resp_adapter

Per-bank request/response adapter placed between the HCI/OBI-style cluster interconnect port and one single-port TCDM bank (plain or ECC-protected, read latency 1). It forwards requests only when response storage is guaranteed, generates `r_valid` one cycle after each granted request, returns the request ID with its response, and buffers responses while the master deasserts `r_ready`. This replaces the bank-side constant `r_valid` tie-off and makes response backpressure and ECC-bank grant stalls safe.

## Interface
- `DataWidth`, 32, data width of bank word.
- `AddrWidth`, 32, request address width; passed through unchanged.
- `BeWidth`, DataWidth/8, byte-enable width.
- `IdWidth`, 1, request/response ID width.
- `RespDepth`, 2, response buffer entries; legal values are 1 and above; 2 gives full throughput.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `s_req_i`  in  1  master request.
- `s_gnt_o`  out  1  request accepted.
- `s_add_i`  in  AddrWidth  byte address.
- `s_wen_i`  in  1  1 = read, 0 = write.
- `s_be_i`  in  BeWidth  byte enables.
- `s_data_i`  in  DataWidth  write data.
- `s_id_i`  in  IdWidth  request ID.
- `s_r_valid_o`  out  1  response valid.
- `s_r_ready_i`  in  1  master accepts response.
- `s_r_data_o`  out  DataWidth  read data; 0 for writes.
- `s_r_id_o`  out  IdWidth  ID of the matching request.
- `s_r_err_o`  out  1  uncorrectable ECC error on this read.
- `m_req_o`, `m_add_o`, `m_wen_o`, `m_be_o`, `m_data_o`  out  as s_*  bank request.
- `m_gnt_i`  in  1  bank grant; 1 for plain banks, may drop for ECC banks.
- `m_rdata_i`  in  DataWidth  bank read data, valid the cycle after a granted read.
- `m_err_i`  in  1  bank multi-bit error, sampled together with `m_rdata_i`.
- `occupancy_o`  out  $clog2(RespDepth+1)  buffered-response count, for debug and performance counters.

## Operation
- `credit_ok = (pend_q + count) < RespDepth`. `pend_q` is the in-flight bit. `count` is the buffer occupancy. A pop in the same cycle does not add credit.
- `m_req_o = s_req_i & credit_ok`. `s_gnt_o = m_gnt_i & credit_ok`. Address, write enable, byte enables and data pass through combinationally.
- An accepted request is a cycle where `m_req_o & m_gnt_i` is high. On acceptance, the block sets `pend_q`, latches `id_q <= s_id_i` and latches `rd_q <= s_wen_i`.
- Response cycle is the cycle where `pend_q = 1`. The response word is {data = rd_q ? m_rdata_i : 0, id = id_q, err = rd_q & m_err_i}.
  - If the buffer is empty and `s_r_ready_i = 1`, the response bypasses the buffer and goes straight to the s_r_* outputs.
  - Otherwise the response is pushed into the buffer. It is never dropped, because credit guarantees a free slot.
- When the buffer is non-empty, the head entry drives the s_r_* outputs. The head pops when `s_r_valid_o & s_r_ready_i`.
- Responses stay in request order in all cases. A new response never overtakes a buffered one.
- `pend_q` clears at the end of the response cycle unless a new request is accepted in that same cycle.
- s_r_* outputs hold stable while `s_r_valid_o & ~s_r_ready_i`.

## Timing
- Request accepted at cycle T gives `s_r_valid_o` at T+1 through bypass or buffer. Minimum latency is 1, matching the bank latency.
- Back-to-back throughput with `RespDepth >= 2` and `s_r_ready_i` held high is one request per cycle. With `RespDepth = 1` it is one request every two cycles.
- Buffer full (`count = RespDepth`) forces `s_gnt_o = 0` and `m_req_o = 0`. Buffer empty with `pend_q = 0` forces `s_r_valid_o = 0`.
- A push and a pop in the same cycle leave `count` unchanged. The buffer pointers wrap modulo RespDepth.
- `m_gnt_i = 0` while requesting: no acceptance and no state change. The request waits.
- Reset values: `pend_q = 0`, `count = 0`, `s_r_valid_o = 0`, `s_r_data_o = 0`, `s_r_id_o = 0`, `s_r_err_o = 0`, `occupancy_o = 0`.
- Reset asserted mid-operation discards the in-flight request and all buffered responses immediately. The master must re-issue them.

## Structure
- No shared package. The response struct {data, err, id} is typedef'd locally because its width depends on parameters.
- One sub-module: the response buffer is `fifo_v3` from common_cells.
  - FALL_THROUGH = 0; DEPTH = RespDepth; dtype = response struct.
  - Bypass is handled outside the FIFO.
  - Its `flush_i` and `testmode_i` inputs are tied to 0.
  - Its active-low reset input is driven from `~rst_i`.

## Test plan
- Single read from address 0x10, with the bank returning 0xDEADBEEF and ID 1, and `s_r_ready_i = 1`: expect `s_gnt_o` at T, and `s_r_valid_o` at T+1 with data 0xDEADBEEF, ID 1 and err 0.
- Write with ID 0: expect a response at T+1 with data 0 and ID 0. Bank signals `m_wen_o = 0` and `m_be_o` match the stimulus.
- Four back-to-back reads with RespDepth = 2 and `s_r_ready_i` held low: expect grants on the first two, then `s_gnt_o = 0` and `occupancy_o = 2`. After `s_r_ready_i` rises, expect responses in order, then the remaining two grants.
- ECC bank drops `m_gnt_i` for 3 cycles: expect no acceptance and no response during the stall. The single response arrives one cycle after the grant returns.
- Read with `m_err_i = 1` followed by a clean read: expect err = 1 only on the first response, with IDs preserved.
- Assert `rst_i` while `count = 1` and `pend_q = 1`: expect all outputs at their reset values on the next edge, and no stale response after reset is released.
